// File: rtl/alu_muldiv_sequencer.sv
// Sequencer for unsigned 16x16 multiply and 16/16 divide. Each step issues one add or subtract
// to the shared 74LS181-style ALU, one step per clock; shifting and counting are done locally.
module alu_muldiv_sequencer #(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] ADD_SEL = 4'b1001,
    parameter logic [3:0] SUB_SEL = 4'b0110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_select,
    output logic             alu_mode,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic [1:0]       fsm_state
);

    // Handshakes: a command transfers on a rising edge with in_valid & in_ready; a result
    // transfers on a rising edge with out_valid & out_ready. out_valid holds until taken.
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] m, p, q;
    logic [WIDTH-1:0] p_shl;
    logic             carry, qb;

    always_comb begin
        p_shl = {p[WIDTH-2:0], q[WIDTH-1]};
        carry = ~alu_cout;
        // A bit shifted out of P means the partial remainder already exceeds any divisor.
        qb    = p[WIDTH-1] | ~alu_cout;
    end

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_select = ADD_SEL;
        alu_mode   = 1'b0;
        alu_cin    = 1'b1;
        case (state)
            MUL: begin
                alu_a = p;
                alu_b = m;
            end
            DIV: begin
                alu_a      = p_shl;
                alu_b      = m;
                alu_select = SUB_SEL;
                alu_cin    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            m         <= '0;
            p         <= '0;
            q         <= '0;
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m   <= in_b;
                        p   <= '0;
                        q   <= in_a;
                        cnt <= '0;
                        if (!in_op) begin
                            state <= MUL;
                        end else if (in_b != '0) begin
                            state <= DIV;
                        end else begin
                            state     <= DONE;
                            p         <= in_a;
                            q         <= '1;
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (q[0]) {p, q} <= {carry, alu_f, q[WIDTH-1:1]};
                    else      {p, q} <= {1'b0, p, q[WIDTH-1:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DIV: begin
                    p   <= qb ? alu_f : p_shl;
                    q   <= {q[WIDTH-2:0], qb};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign res_hi    = p;
    assign res_lo    = q;
    assign fsm_state = state;

endmodule
